// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU (C) has fixed priority, UART engine (U) gets a starvation
// guarantee and optional burst lock. Optional statistics counters under DM_ARB_STATS_EN.
module dm_port_arbiter #(
  parameter int ADDR_BITS  = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [ADDR_BITS-1:0] c_addr,
  input  logic [31:0]          c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [31:0]          c_rdata,
  output logic                 cpu_stall,
  input  logic                 u_req,
  input  logic                 u_we,
  input  logic                 u_lock,
  input  logic [ADDR_BITS-1:0] u_addr,
  input  logic [31:0]          u_wdata,
  output logic                 u_gnt,
  output logic                 u_rvalid,
  output logic [31:0]          u_rdata,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]          stat_conflicts,
  output logic [15:0]          stat_u_wait
`endif
);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_U, LOCK_U} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        u_force;
  logic        c_tag, u_tag;
  logic [31:0] c_rdata_q, u_rdata_q;

  // U wins outright while it holds a burst lock or once C has had its quota.
  assign u_force = u_req & ((state == LOCK_U) | (starve_cnt == STARVE_LIM));

  always_comb begin
    u_gnt      = u_req & (u_force | ~c_req);
    c_gnt      = c_req & ~u_force;
    state_nxt  = IDLE;
    starve_nxt = starve_cnt;
    if (c_gnt)                state_nxt = OWN_C;
    else if (u_gnt && u_lock) state_nxt = LOCK_U;
    else if (u_gnt)           state_nxt = OWN_U;
    if (!u_req || u_gnt)
      starve_nxt = '0;
    else if (c_gnt && starve_cnt != STARVE_LIM)
      starve_nxt = starve_cnt + 4'd1;
  end

  assign cpu_stall = c_req & ~c_gnt;
  assign mem_addr  = u_gnt ? u_addr  : c_addr;
  assign mem_wdata = u_gnt ? u_wdata : c_wdata;
  // Writes commit on the edge, so suppress them while reset is held.
  assign mem_we    = reset & ((c_gnt & c_we) | (u_gnt & u_we));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      c_tag      <= 1'b0;
      u_tag      <= 1'b0;
      c_rdata_q  <= '0;
      u_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      c_tag      <= c_gnt & ~c_we;
      u_tag      <= u_gnt & ~u_we;
      if (c_tag) c_rdata_q <= mem_rdata;
      if (u_tag) u_rdata_q <= mem_rdata;
    end
  end

  // Memory read data arrives the cycle after the address; the tag steers it to its owner.
  assign c_rvalid = c_tag;
  assign u_rvalid = u_tag;
  assign c_rdata  = c_tag ? mem_rdata : c_rdata_q;
  assign u_rdata  = u_tag ? mem_rdata : u_rdata_q;

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_conflicts <= '0;
      stat_u_wait    <= '0;
    end else begin
      if (c_req && u_req && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (u_req && !u_gnt && stat_u_wait != 16'hFFFF)
        stat_u_wait <= stat_u_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural synchronous memory and a
// read-data scoreboard per requester.
module tb_dm_port_arbiter;

  logic        clk, reset;
  logic        c_req, c_we, u_req, u_we, u_lock;
  logic [8:0]  c_addr, u_addr, mem_addr;
  logic [31:0] c_wdata, u_wdata, mem_wdata, mem_rdata, c_rdata, u_rdata;
  logic        c_gnt, c_rvalid, cpu_stall, u_gnt, u_rvalid, mem_we;
`ifdef DM_ARB_STATS_EN
  logic [15:0] stat_conflicts, stat_u_wait;
`endif

  dm_port_arbiter #(.ADDR_BITS(9), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
    .u_req(u_req), .u_we(u_we), .u_lock(u_lock), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_gnt(u_gnt), .u_rvalid(u_rvalid), .u_rdata(u_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DM_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_u_wait(stat_u_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten words hold an address-derived pattern.
  bit [31:0] wdat [512];
  bit        wval [512];

  function automatic logic [31:0] mem_val(input logic [8:0] a);
    return wval[a] ? wdat[a] : (32'hC0DE0000 | {23'd0, a});
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      wdat[mem_addr] <= mem_wdata;
      wval[mem_addr] <= 1'b1;
    end
    mem_rdata <= mem_val(mem_addr);
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cq[$], uq[$];
  logic        c_pend = 1'b0, u_pend = 1'b0;
  logic [31:0] c_last = '0, u_last = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                      input logic ur, input logic uw, input logic ul, input logic [8:0] ua,
                      input logic [31:0] ud, input logic ec, input logic eu, input string tag);
    logic [31:0] e;
    @(negedge clk);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    u_req = ur; u_we = uw; u_lock = ul; u_addr = ua; u_wdata = ud;
    #1;
    chk({tag, ".c_gnt"}, 32'(c_gnt), 32'(ec));
    chk({tag, ".u_gnt"}, 32'(u_gnt), 32'(eu));
    chk({tag, ".stall"}, 32'(cpu_stall), 32'(cr & ~ec));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(reset & ((ec & cw) | (eu & uw))));
    if (ec | eu) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(eu ? ua : ca));
    chk({tag, ".c_rvalid"}, 32'(c_rvalid), 32'(c_pend));
    chk({tag, ".u_rvalid"}, 32'(u_rvalid), 32'(u_pend));
    if (c_pend) begin
      e = (cq.size() > 0) ? cq.pop_front() : 32'hXXXXXXXX;
      c_last = e;
    end
    chk({tag, ".c_rdata"}, c_rdata, c_last);
    if (u_pend) begin
      e = (uq.size() > 0) ? uq.pop_front() : 32'hXXXXXXXX;
      u_last = e;
    end
    chk({tag, ".u_rdata"}, u_rdata, u_last);
    c_pend = ec & ~cw & reset;
    u_pend = eu & ~uw & reset;
    if (c_pend) cq.push_back(mem_val(ca));
    if (u_pend) uq.push_back(mem_val(ua));
  endtask

  task automatic idle(input string tag);
    step(0, 0, 9'h0, 0, 0, 0, 0, 9'h0, 0, 0, 0, tag);
  endtask

  initial begin
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    u_req = 0; u_we = 0; u_lock = 0; u_addr = '0; u_wdata = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.c_rvalid", 32'(c_rvalid), 0);
    chk("rst.u_rvalid", 32'(u_rvalid), 0);
    chk("rst.c_rdata", c_rdata, 0);
    chk("rst.u_rdata", u_rdata, 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    @(negedge clk) reset = 1'b1;

    // Lone CPU read, then C write and read-back.
    step(1, 0, 9'h010, 0, 0, 0, 0, 9'h0, 0, 1, 0, "c_rd");
    idle("c_rd.ret");
    step(1, 1, 9'h007, 32'h12345678, 0, 0, 0, 9'h0, 0, 1, 0, "c_wr");
    step(1, 0, 9'h007, 0, 0, 0, 0, 9'h0, 0, 1, 0, "c_rdback");
    idle("c_rdback.ret");
    chk("c_rdback.val", c_rdata, 32'h12345678);

    // Both requesting continuously: C,C,C,C,U repeating.
    for (int i = 0; i < 10; i++)
      step(1, 0, 9'(9'h020 + i), 0, 1, 0, 0, 9'(9'h040 + i), 0,
           (i % 5) != 4, (i % 5) == 4, $sformatf("starve%0d", i));
    idle("starve.ret");
`ifdef DM_ARB_STATS_EN
    chk("stat_conflicts", 32'(stat_conflicts), 10);
    chk("stat_u_wait", 32'(stat_u_wait), 8);
`endif

    // Locked U burst of 3 writes obtained through the starvation limit.
    for (int i = 0; i < 4; i++)
      step(1, 0, 9'(9'h050 + i), 0, 1, 1, 1, 9'h1FD, 32'hDEADBEEF, 1, 0, $sformatf("lk_c%0d", i));
    step(1, 0, 9'h054, 0, 1, 1, 1, 9'h1FD, 32'hDEADBEEF, 0, 1, "lk_u0");
    step(1, 0, 9'h054, 0, 1, 1, 1, 9'h1FE, 32'hDEADBEEF, 0, 1, "lk_u1");
    step(1, 0, 9'h054, 0, 1, 1, 0, 9'h1FF, 32'hDEADBEEF, 0, 1, "lk_u2");
    step(1, 0, 9'h054, 0, 0, 0, 0, 9'h0,   0,            1, 0, "lk_c4");
    step(1, 0, 9'h1FF, 0, 0, 0, 0, 9'h0,   0,            1, 0, "lk_rd");
    idle("lk_rd.ret");
    chk("lk_rd.val", c_rdata, 32'hDEADBEEF);

    // U read then C read: data returns to the right owner.
    step(0, 0, 9'h0,   0, 1, 0, 0, 9'h005, 0, 0, 1, "x_u");
    step(1, 0, 9'h006, 0, 0, 0, 0, 9'h0,   0, 1, 0, "x_c");
    idle("x.ret");
    chk("x.u_hold", u_rdata, 32'hC0DE0005);
    chk("x.c_val", c_rdata, 32'hC0DE0006);

    // Lock exits when U drops its request.
    step(0, 0, 9'h0,   0, 1, 1, 1, 9'h070, 32'h1, 0, 1, "lx_u");
    step(1, 0, 9'h071, 0, 0, 0, 0, 9'h0,   0,     1, 0, "lx_c");
    idle("lx.ret");

    // Reset right after a C read grant discards the in-flight read.
    step(1, 0, 9'h010, 0, 0, 0, 0, 9'h0, 0, 1, 0, "rr_c");
    #1 reset = 1'b0;
    c_pend = 1'b0; cq.delete(); c_last = '0; u_last = '0;
    step(1, 1, 9'h033, 32'hAA, 0, 0, 0, 9'h0, 0, 1, 0, "rr_hold");
    @(negedge clk) reset = 1'b1;
    idle("rr_rel");

    // Reset out of LOCK_U returns to IDLE: C wins next.
    step(0, 0, 9'h0, 0, 1, 1, 1, 9'h060, 32'h11, 0, 1, "rl_u");
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    step(1, 0, 9'h061, 0, 1, 0, 1, 9'h062, 0, 1, 0, "rl_idle");
    idle("rl.ret");
    idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
